bip_control_unit: RTL

//   Sequencer for the BIP accumulator datapath: fetches 16-bit instructions, decodes the

---
 rtl/bip_control_unit_pkg.sv | 55 +++++
 rtl/bip_control_unit_decoder.sv | 46 ++++
 rtl/bip_control_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bip_control_unit_pkg.sv
// Shared definitions for the BIP control unit: default widths, opcode values,
// accumulator/ALU select codes, FSM state encodings and the EXEC control word.
// No ports; imported by bip_control_unit and bip_control_unit_decoder.
package bip_control_unit_pkg;

    localparam int NBITS_I_DEF   = 16;
    localparam int NBITS_OPC_DEF = 5;
    localparam int NBITS_OP_DEF  = 11;
    localparam int NBITS_PC_DEF  = 11;

    // Opcodes; every value from 01000 upward is a NOP.
    localparam logic [NBITS_OPC_DEF-1:0] OPC_HLT  = 5'b00000;
    localparam logic [NBITS_OPC_DEF-1:0] OPC_STO  = 5'b00001;
    localparam logic [NBITS_OPC_DEF-1:0] OPC_LD   = 5'b00010;
    localparam logic [NBITS_OPC_DEF-1:0] OPC_LDI  = 5'b00011;
    localparam logic [NBITS_OPC_DEF-1:0] OPC_ADD  = 5'b00100;
    localparam logic [NBITS_OPC_DEF-1:0] OPC_ADDI = 5'b00101;
    localparam logic [NBITS_OPC_DEF-1:0] OPC_SUB  = 5'b00110;
    localparam logic [NBITS_OPC_DEF-1:0] OPC_SUBI = 5'b00111;

    // Accumulator source select.
    localparam logic [1:0] SELA_MEM  = 2'b00;
    localparam logic [1:0] SELA_EXT  = 2'b01;
    localparam logic [1:0] SELA_ALU  = 2'b10;
    localparam logic [1:0] SELA_HOLD = 2'b11;

    // ALU B operand select and ALU operation.
    localparam logic SELB_MEM = 1'b0;
    localparam logic SELB_EXT = 1'b1;
    localparam logic ALU_ADD  = 1'b0;
    localparam logic ALU_SUB  = 1'b1;

    // FSM state encodings.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_MEMRD  = 3'd3;
    localparam logic [2:0] ST_EXEC   = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    // Strobes/selects that are only meaningful during EXEC.
    typedef struct packed {
        logic [1:0] sela;
        logic       selb;
        logic       wr_acc;
        logic       alu_op;
        logic       wr_ram;
    } exec_ctrl_t;

    // Inactive control word: accumulator holds, nothing written.
    localparam exec_ctrl_t EXEC_CTRL_IDLE = '{sela: SELA_HOLD, selb: SELB_MEM,
                                              wr_acc: 1'b0, alu_op: ALU_ADD,
                                              wr_ram: 1'b0};

endpackage

// File: rtl/bip_control_unit_decoder.sv
// Opcode decoder: maps an opcode to the EXEC control word plus flags that steer the FSM.
// Ports: i_opcode (in) -> o_ctrl (EXEC selects/strobes), o_needs_mem (operand read
// from data memory first), o_is_halt (HLT). Purely combinational.
module bip_control_unit_decoder
    import bip_control_unit_pkg::*;
(
    input  logic [NBITS_OPC_DEF-1:0] i_opcode,
    output exec_ctrl_t               o_ctrl,
    output logic                     o_needs_mem,
    output logic                     o_is_halt
);

    always_comb begin
        o_ctrl      = EXEC_CTRL_IDLE;
        o_needs_mem = 1'b0;
        o_is_halt   = 1'b0;
        case (i_opcode)
            OPC_HLT:  o_is_halt = 1'b1;
            OPC_STO:  o_ctrl.wr_ram = 1'b1;
            OPC_LD: begin
                o_ctrl.sela   = SELA_MEM;
                o_ctrl.wr_acc = 1'b1;
                o_needs_mem   = 1'b1;
            end
            OPC_LDI: begin
                o_ctrl.sela   = SELA_EXT;
                o_ctrl.wr_acc = 1'b1;
            end
            OPC_ADD, OPC_SUB: begin
                o_ctrl.sela   = SELA_ALU;
                o_ctrl.selb   = SELB_MEM;
                o_ctrl.wr_acc = 1'b1;
                o_ctrl.alu_op = (i_opcode == OPC_SUB) ? ALU_SUB : ALU_ADD;
                o_needs_mem   = 1'b1;
            end
            OPC_ADDI, OPC_SUBI: begin
                o_ctrl.sela   = SELA_ALU;
                o_ctrl.selb   = SELB_EXT;
                o_ctrl.wr_acc = 1'b1;
                o_ctrl.alu_op = (i_opcode == OPC_SUBI) ? ALU_SUB : ALU_ADD;
            end
            default: ; // NOP: inactive control word, PC still advances
        endcase
    end

endmodule

// File: rtl/bip_control_unit.sv
// BIP control unit: multi-cycle Moore FSM (IDLE/FETCH/DECODE/MEMRD/EXEC/HALT) that fetches,
// decodes and sequences one instruction at a time. Ports: i_clk, i_reset (async, high),
// i_start, i_instr in; o_pc/o_instr_rd, o_op_addr/o_rd_ram/o_wr_ram, o_SelA/o_SelB/o_WrAcc/
// o_alu_op, o_busy/o_halted out. Optional macro BIP_INSTR_COUNT_EN adds o_instr_cnt[31:0].
module bip_control_unit
    import bip_control_unit_pkg::*;
#(
    parameter int NBITS_I   = NBITS_I_DEF,
    parameter int NBITS_OPC = NBITS_OPC_DEF,
    parameter int NBITS_OP  = NBITS_OP_DEF,
    parameter int NBITS_PC  = NBITS_PC_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NBITS_I-1:0]  i_instr,
    output logic [NBITS_PC-1:0] o_pc,
    output logic                o_instr_rd,
    output logic [NBITS_OP-1:0] o_op_addr,
    output logic                o_rd_ram,
    output logic                o_wr_ram,
    output logic [1:0]          o_SelA,
    output logic                o_SelB,
    output logic                o_WrAcc,
    output logic                o_alu_op,
    output logic                o_busy,
    output logic                o_halted
`ifdef BIP_INSTR_COUNT_EN
    ,
    output logic [31:0]         o_instr_cnt
`endif
);

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [NBITS_PC-1:0] r_pc;
    logic [NBITS_OP-1:0] r_operand;
    exec_ctrl_t          r_ctrl;
    exec_ctrl_t          w_dec_ctrl;
    logic                w_dec_needs_mem;
    logic                w_dec_is_halt;
    logic                w_in_exec;

    // The instruction word arrives during DECODE; it is decoded there and the control
    // word is registered alongside the operand, so every output depends only on flops.
    bip_control_unit_decoder u_decoder (
        .i_opcode    (i_instr[NBITS_I-1:NBITS_I-NBITS_OPC]),
        .o_ctrl      (w_dec_ctrl),
        .o_needs_mem (w_dec_needs_mem),
        .o_is_halt   (w_dec_is_halt)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_start) w_state_next = ST_FETCH;
            ST_FETCH:  w_state_next = ST_DECODE;
            ST_DECODE: begin
                if (w_dec_is_halt)        w_state_next = ST_HALT;
                else if (w_dec_needs_mem) w_state_next = ST_MEMRD;
                else                      w_state_next = ST_EXEC;
            end
            ST_MEMRD:  w_state_next = ST_EXEC;
            ST_EXEC:   w_state_next = ST_FETCH;
            ST_HALT:   w_state_next = ST_HALT;   // left only through reset
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_operand <= '0;
            r_ctrl    <= EXEC_CTRL_IDLE;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && i_start) begin
                r_pc <= '0;
            end else if (r_state == ST_EXEC) begin
                r_pc <= r_pc + NBITS_PC'(1);  // wraps silently at the top of program memory
            end
            if (r_state == ST_DECODE) begin
                r_operand <= i_instr[NBITS_OP-1:0];
                r_ctrl    <= w_dec_ctrl;
            end
        end
    end

`ifdef BIP_INSTR_COUNT_EN
    logic [31:0] r_instr_cnt;

    // Counts completed EXEC cycles; HLT never reaches EXEC so it is not counted.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_instr_cnt <= '0;
        end else if (r_state == ST_EXEC) begin
            r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    assign o_instr_cnt = r_instr_cnt;
`endif

    assign w_in_exec = (r_state == ST_EXEC);

    assign o_pc       = r_pc;
    assign o_instr_rd = (r_state == ST_FETCH);
    assign o_rd_ram   = (r_state == ST_MEMRD);
    assign o_op_addr  = (r_state == ST_MEMRD || w_in_exec) ? r_operand : '0;
    assign o_SelA     = w_in_exec ? r_ctrl.sela : SELA_HOLD;
    assign o_SelB     = w_in_exec & r_ctrl.selb;
    assign o_WrAcc    = w_in_exec & r_ctrl.wr_acc;
    assign o_alu_op   = w_in_exec & r_ctrl.alu_op;
    assign o_wr_ram   = w_in_exec & r_ctrl.wr_ram;
    assign o_busy     = (r_state == ST_FETCH) || (r_state == ST_DECODE) ||
                        (r_state == ST_MEMRD) || w_in_exec;
    assign o_halted   = (r_state == ST_HALT);

endmodule
